// File: rtl/fifo_access_ctrl.sv
// Access controller in front of a 32-bit FIFO/LIFO storage block.
// Two requesters share the write port under round-robin arbitration.
// A read scheduler drains the store either in fixed bursts, once enough
// words are committed, or completely when a flush is requested.
module fifo_access_ctrl #(
    parameter int DEPTH     = 8,
    parameter int BURST_LEN = 4,
    parameter int CW        = 4
) (
    input  logic          Clk,
    input  logic          Rst_n,
    input  logic          Req0,
    input  logic [31:0]   Data0,
    output logic          Gnt0,
    input  logic          Req1,
    input  logic [31:0]   Data1,
    output logic          Gnt1,
    input  logic          Flush,
    output logic [31:0]   Datain,
    output logic          Wren,
    output logic          Rden,
    output logic [CW-1:0] Count,
    output logic          Busy,
    output logic          Done
);

    localparam int DATA_W = 32;

    // Thresholds pre-sized to the occupancy width so comparisons stay width-matched.
    localparam logic [CW:0]   DEPTH_W    = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0] BURST_THR  = CW'(BURST_LEN);
    localparam logic [CW-1:0] BURST_LAST = CW'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              rden_nxt;
    logic              done_nxt;
    logic              flush_lat;
    logic              flush_lat_nxt;
    logic [CW-1:0]     bcnt;
    logic [CW-1:0]     bcnt_nxt;
    logic [CW-1:0]     drain_left;

    logic              prio1;
    logic [CW:0]       fill_p0;
    logic              space_p0;
    logic              accept_p0;
    logic              pick1_p0;
    logic [DATA_W-1:0] data_p0;

    // Arbitration stage: decide which requester (if any) is accepted this edge.
    // The in-flight write counts against space because it is not yet in Count.
    always_comb begin
        fill_p0   = {1'b0, Count} + (CW + 1)'(Wren);
        space_p0  = (fill_p0 < DEPTH_W);
        accept_p0 = (Req0 | Req1) & space_p0;
        // A lone request wins outright; on contention the pointer decides.
        pick1_p0  = Req1 & (~Req0 | prio1);
        data_p0   = pick1_p0 ? Data1 : Data0;
    end

    // Write port register: the accepted word and its grant appear one cycle later.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Wren   <= 1'b0;
            Gnt0   <= 1'b0;
            Gnt1   <= 1'b0;
            Datain <= '0;
            prio1  <= 1'b0;
        end else begin
            Wren <= accept_p0;
            Gnt0 <= accept_p0 & ~pick1_p0;
            Gnt1 <= accept_p0 & pick1_p0;
            if (accept_p0) begin
                Datain <= data_p0;
                // Pointer moves only on an accept, toward the side not just served.
                prio1  <= ~pick1_p0;
            end
        end
    end

    // Committed occupancy follows the write and read strobes actually issued.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Count <= '0;
        end else begin
            Count <= Count + CW'(Wren) - CW'(Rden);
        end
    end

    // Words still committed after the read already issued this cycle; an
    // in-flight write is deliberately excluded so it is never read early.
    always_comb begin
        drain_left = Count - CW'(Rden);
    end

    // Read scheduler next-state and registered-output decode.
    always_comb begin
        state_nxt     = state;
        rden_nxt      = 1'b0;
        done_nxt      = 1'b0;
        bcnt_nxt      = bcnt;
        flush_lat_nxt = flush_lat | Flush;
        case (state)
            IDLE: begin
                // A pending flush outranks a burst threshold.
                if (flush_lat | Flush) begin
                    if (Count != '0) begin
                        state_nxt = FLUSH;
                        rden_nxt  = 1'b1;
                    end else if (!Wren) begin
                        // Nothing stored and nothing arriving: acknowledge at once.
                        done_nxt      = 1'b1;
                        flush_lat_nxt = 1'b0;
                    end
                end else if (Count >= BURST_THR) begin
                    state_nxt = BURST;
                    rden_nxt  = 1'b1;
                    bcnt_nxt  = BURST_LAST;
                end
            end
            BURST: begin
                // bcnt holds the reads still owed after the current one.
                if (bcnt == '0) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end else begin
                    bcnt_nxt = bcnt - 1'b1;
                    rden_nxt = 1'b1;
                end
            end
            FLUSH: begin
                if (drain_left != '0) begin
                    rden_nxt = 1'b1;
                end else begin
                    state_nxt     = IDLE;
                    done_nxt      = 1'b1;
                    // A fresh pulse landing on completion starts another drain.
                    flush_lat_nxt = Flush;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Read scheduler state register; reset aborts any burst without a Done.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state     <= IDLE;
            Rden      <= 1'b0;
            Done      <= 1'b0;
            bcnt      <= '0;
            flush_lat <= 1'b0;
        end else begin
            state     <= state_nxt;
            Rden      <= rden_nxt;
            Done      <= done_nxt;
            bcnt      <= bcnt_nxt;
            flush_lat <= flush_lat_nxt;
        end
    end

    // Busy reflects any read activity in progress.
    always_comb begin
        Busy = (state != IDLE);
    end

endmodule

// File: tb/tb_fifo_access_ctrl.sv
// Bench for fifo_access_ctrl: directed scenarios plus randomized traffic,
// checked every cycle against a behavioural model of the controller.
module tb_fifo_access_ctrl;

    localparam int DEPTH     = 8;
    localparam int BURST_LEN = 4;
    localparam int CW        = 4;

    localparam int M_REST  = 0;
    localparam int M_BURST = 1;
    localparam int M_DRAIN = 2;

    logic          Clk = 1'b0;
    logic          Rst_n;
    logic          Req0, Req1, Flush;
    logic [31:0]   Data0, Data1, Datain;
    logic          Gnt0, Gnt1, Wren, Rden, Busy, Done;
    logic [CW-1:0] Count;

    logic          f_req1;
    logic [31:0]   f_datain;
    logic          f_gnt0, f_gnt1, f_wren, f_rden, f_busy, f_done;
    logic [CW-1:0] f_count;

    always #5 Clk = ~Clk;

    fifo_access_ctrl #(.DEPTH(DEPTH), .BURST_LEN(BURST_LEN), .CW(CW)) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .Req0(Req0), .Data0(Data0), .Gnt0(Gnt0),
        .Req1(Req1), .Data1(Data1), .Gnt1(Gnt1),
        .Flush(Flush), .Datain(Datain), .Wren(Wren), .Rden(Rden),
        .Count(Count), .Busy(Busy), .Done(Done)
    );

    // Second instance with a full-depth burst so the store can fill completely.
    fifo_access_ctrl #(.DEPTH(8), .BURST_LEN(8), .CW(4)) u_full (
        .Clk(Clk), .Rst_n(Rst_n),
        .Req0(1'b0), .Data0(32'h0), .Gnt0(f_gnt0),
        .Req1(f_req1), .Data1(32'h5), .Gnt1(f_gnt1),
        .Flush(1'b0), .Datain(f_datain), .Wren(f_wren), .Rden(f_rden),
        .Count(f_count), .Busy(f_busy), .Done(f_done)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int          e_count;
    bit          e_wren, e_rden, e_done, e_g0, e_g1;
    logic [31:0] e_data;
    int          m_mode;
    int          reads_done;
    bit          flush_pending;
    bit          turn1;

    // Directed-scenario statistics
    int          rden_cyc, done_cnt, g0_cnt;
    logic [31:0] wq[$];
    logic [31:0] single_pat [5] = '{32'd20, 32'd10, 32'd30, 32'd40, 32'd50};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        e_count = 0; e_wren = 0; e_rden = 0; e_done = 0; e_g0 = 0; e_g1 = 0;
        e_data = 32'h0; m_mode = M_REST; reads_done = 0;
        flush_pending = 0; turn1 = 0;
    endtask

    // One clock edge of the controller, derived from its behavioural rules.
    task automatic model_edge();
        int nxt_count;
        bit n_wren, n_g0, n_g1, n_rden, n_done, take1, want_flush;
        n_wren = 0; n_g0 = 0; n_g1 = 0; n_rden = 0; n_done = 0; take1 = 0;
        if ((Req0 || Req1) && (e_count + int'(e_wren)) < DEPTH) begin
            take1  = Req1 && (!Req0 || turn1);
            n_wren = 1; n_g0 = !take1; n_g1 = take1;
            e_data = take1 ? Data1 : Data0;
            turn1  = !take1;
        end
        nxt_count  = e_count + int'(e_wren) - int'(e_rden);
        want_flush = flush_pending || Flush;
        case (m_mode)
            M_REST: begin
                if (want_flush) begin
                    if (e_count > 0) begin
                        m_mode = M_DRAIN; n_rden = 1; flush_pending = 1;
                    end else if (!e_wren) begin
                        n_done = 1; flush_pending = 0;
                    end else begin
                        flush_pending = 1;
                    end
                end else if (e_count >= BURST_LEN) begin
                    m_mode = M_BURST; reads_done = 1; n_rden = 1;
                end
            end
            M_BURST: begin
                if (Flush) flush_pending = 1;
                if (reads_done == BURST_LEN) begin
                    m_mode = M_REST; n_done = 1;
                end else begin
                    reads_done++; n_rden = 1;
                end
            end
            default: begin
                if (e_count - int'(e_rden) > 0) begin
                    n_rden = 1;
                end else begin
                    m_mode = M_REST; n_done = 1; flush_pending = Flush;
                end
            end
        endcase
        e_count = nxt_count;
        e_wren = n_wren; e_g0 = n_g0; e_g1 = n_g1; e_rden = n_rden; e_done = n_done;
    endtask

    task automatic compare_all();
        chk("wren", 32'(Wren), 32'(e_wren));
        chk("gnt0", 32'(Gnt0), 32'(e_g0));
        chk("gnt1", 32'(Gnt1), 32'(e_g1));
        chk("rden", 32'(Rden), 32'(e_rden));
        chk("done", 32'(Done), 32'(e_done));
        chk("count", 32'(Count), e_count);
        chk("busy", 32'(Busy), 32'(m_mode != M_REST));
        chk("one_grant", 32'(Gnt0 & Gnt1), 32'd0);
        if (e_wren) chk("datain", Datain, e_data);
        if (Rden) rden_cyc++;
        if (Done) done_cnt++;
        if (Gnt0) g0_cnt++;
        if (Wren) wq.push_back(Datain);
    endtask

    task automatic step();
        @(posedge Clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_wren"},   32'(Wren),  32'd0);
        chk({tag, "_gnt0"},   32'(Gnt0),  32'd0);
        chk({tag, "_gnt1"},   32'(Gnt1),  32'd0);
        chk({tag, "_rden"},   32'(Rden),  32'd0);
        chk({tag, "_done"},   32'(Done),  32'd0);
        chk({tag, "_busy"},   32'(Busy),  32'd0);
        chk({tag, "_count"},  32'(Count), 32'd0);
        chk({tag, "_datain"}, Datain,     32'd0);
    endtask

    task automatic rand_traffic(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            if (!Req0 || e_g0) begin
                Req0 = ($urandom_range(0, 3) != 0); Data0 = $urandom;
            end
            if (!Req1 || e_g1) begin
                Req1 = ($urandom_range(0, 3) != 0); Data1 = $urandom;
            end
            Flush = ($urandom_range(0, 19) == 0);
            step();
        end
        Req0 = 0; Req1 = 0; Flush = 0;
    endtask

    task automatic clear_store();
        Flush = 1; step(); Flush = 0;
        repeat (20) step();
        chk("store_empty", 32'(Count), 32'd0);
    endtask

    initial begin
        int  f_gnts;
        bit  seen8, resumed;

        Rst_n = 1; Req0 = 0; Req1 = 0; Flush = 0; Data0 = 0; Data1 = 0; f_req1 = 0;
        #2 Rst_n = 0;
        #1;
        reset_model();
        check_zero("por");
        repeat (2) @(posedge Clk);
        #1 Rst_n = 1;
        step();

        // Single requester streaming five words
        rden_cyc = 0; done_cnt = 0; g0_cnt = 0; wq.delete();
        for (int i = 0; i < 5; i++) begin
            Req0 = 1; Data0 = single_pat[i]; step();
        end
        Req0 = 0;
        repeat (10) step();
        chk("single_words", 32'(wq.size()), 32'd5);
        for (int i = 0; i < 5 && i < wq.size(); i++) chk("single_data", wq[i], single_pat[i]);
        chk("single_gnt0", 32'(g0_cnt), 32'd5);
        chk("single_rden", 32'(rden_cyc), 32'(BURST_LEN));
        chk("single_done", 32'(done_cnt), 32'd1);
        chk("single_count", 32'(Count), 32'd1);

        // Reset held for three cycles in the middle of traffic
        rand_traffic(20);
        Req0 = 1; Req1 = 1; Data0 = $urandom; Data1 = $urandom;
        step();
        Rst_n = 0; Req0 = 0; Req1 = 0;
        #1;
        reset_model();
        check_zero("rst_async");
        repeat (3) @(posedge Clk);
        #1;
        check_zero("rst_hold");
        Rst_n = 1;

        // Contention from a fresh pointer: words alternate starting with Req0
        wq.delete();
        Req0 = 1; Req1 = 1; Data0 = 32'hA; Data1 = 32'hB;
        repeat (10) step();
        Req0 = 0; Req1 = 0;
        chk("contend_words", 32'(wq.size() >= 8), 32'd1);
        for (int i = 0; i < 8 && i < wq.size(); i++)
            chk("contend_data", wq[i], (i % 2 == 0) ? 32'hA : 32'hB);
        clear_store();

        // Flush draining three committed words
        Req0 = 1;
        repeat (3) begin Data0 = $urandom; step(); end
        Req0 = 0;
        repeat (2) step();
        chk("flush_pre_count", 32'(Count), 32'd3);
        rden_cyc = 0; done_cnt = 0;
        Flush = 1; step(); Flush = 0;
        chk("flush_busy", 32'(Busy), 32'd1);
        repeat (6) step();
        chk("flush_rden", 32'(rden_cyc), 32'd3);
        chk("flush_done", 32'(done_cnt), 32'd1);
        chk("flush_count", 32'(Count), 32'd0);

        // Flush of an empty store
        rden_cyc = 0; done_cnt = 0;
        Flush = 1; step(); Flush = 0;
        chk("eflush_done_now", 32'(Done), 32'd1);
        repeat (3) step();
        chk("eflush_rden", 32'(rden_cyc), 32'd0);
        chk("eflush_done", 32'(done_cnt), 32'd1);

        // Flush arriving in the second cycle of a burst entered at Count=6
        rden_cyc = 0; done_cnt = 0;
        Req0 = 1;
        repeat (10) begin Data0 = $urandom; step(); end
        Req0 = 0;
        step();
        chk("simul_entry_count", 32'(Count), 32'd6);
        chk("simul_entry_rden", 32'(Rden), 32'd1);
        step();
        Flush = 1; step(); Flush = 0;
        repeat (10) step();
        chk("simul_rden", 32'(rden_cyc), 32'd10);
        chk("simul_done", 32'(done_cnt), 32'd3);
        chk("simul_count", 32'(Count), 32'd0);

        // Reset in the middle of a burst
        Req0 = 1;
        repeat (4) begin Data0 = $urandom; step(); end
        Req0 = 0;
        repeat (2) step();
        chk("mb_in_burst", 32'(Rden), 32'd1);
        step();
        Rst_n = 0;
        #1;
        reset_model();
        chk("mb_rden_drop", 32'(Rden), 32'd0);
        chk("mb_busy_drop", 32'(Busy), 32'd0);
        chk("mb_count", 32'(Count), 32'd0);
        chk("mb_no_done", 32'(Done), 32'd0);
        repeat (2) @(posedge Clk);
        #1;
        chk("mb_no_done_later", 32'(Done), 32'd0);
        Rst_n = 1;

        // Fill the full-depth instance from one requester
        f_req1 = 1; f_gnts = 0; seen8 = 0; resumed = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (f_gnt1) begin
                if (seen8) resumed = 1;
                else f_gnts++;
            end
            chk("full_gnt_at_8", 32'(f_gnt1 && (f_count == 4'd8)), 32'd0);
            chk("full_no_gnt0", 32'(f_gnt0), 32'd0);
            if (f_count == 4'd8 && !seen8) begin
                seen8 = 1;
                chk("full_gnt_count", 32'(f_gnts), 32'd8);
            end
        end
        f_req1 = 0;
        chk("full_reached", 32'(seen8), 32'd1);
        chk("full_resumed", 32'(resumed), 32'd1);

        // Long randomized run
        rand_traffic(400);
        repeat (20) step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_access_ctrl.md
Name: fifo_access_ctrl

Overview:
- Controller in front of the 32-bit LIFO/FIFO storage block; drives that block's Datain/Wren/Rden.
- Arbitrates two write requesters round-robin and tracks committed occupancy.
- Schedules reads as fixed-length bursts when occupancy reaches a threshold, or as a full drain on Flush.

Parameters:
- DEPTH, 8, storage depth in words; must match the attached FIFO.
- BURST_LEN, 4, words read per burst; 1 <= BURST_LEN <= DEPTH.
- CW, 4, width of Count; must satisfy 2^CW > DEPTH.

Ports:
- Clk  input  1  rising-edge clock
- Rst_n  input  1  asynchronous active-low reset
- Req0  input  1  requester 0 write request; held until granted
- Data0  input  32  requester 0 write data
- Gnt0  output  1  registered 1-cycle pulse: requester 0 word accepted
- Req1  input  1  requester 1 write request
- Data1  input  32  requester 1 write data
- Gnt1  output  1  registered 1-cycle pulse: requester 1 word accepted
- Flush  input  1  1-cycle pulse: drain all stored words
- Datain  output  32  write data to the FIFO
- Wren  output  1  write enable to the FIFO
- Rden  output  1  read enable to the FIFO
- Count  output  CW  committed occupancy
- Busy  output  1  read FSM is not IDLE
- Done  output  1  1-cycle pulse at the end of a burst or flush

Behaviour:
- Reset (Rst_n low, asynchronous): all outputs are 0, FSM=IDLE, round-robin pointer favours Req0, flush latch is cleared.
- Reset mid-burst aborts at once: Rden drops with no Done pulse.
- Accept condition on a clock edge: a request is pending and Space = (Count + Wren) < DEPTH.
- On accept, the next cycle has Wren=1, Datain=the granted word, and Gnt of the winner=1.
- Write latency is 1 cycle from the request edge. At most one accept per cycle.
- Round robin:
  - If both requests are pending, the side not served last wins.
  - A lone request wins regardless of the pointer.
  - The pointer updates only on an accept.
- Count:
  - next = Count + Wren - Rden, evaluated on every edge.
  - A write and a read in the same cycle leave Count unchanged.
  - Count never exceeds DEPTH and never underflows.
- Read FSM states: IDLE, BURST, FLUSH.
  - IDLE->BURST when Count >= BURST_LEN and no flush is latched. Rden is held high for exactly BURST_LEN consecutive cycles. Done pulses in the cycle after the last Rden, then the FSM returns to IDLE.
  - IDLE->FLUSH when a flush is latched and Count > 0. Rden is held high while (Count - Rden) > 0, counting only committed words; an in-flight Wren is not read that cycle. Done pulses when the drain completes, the latch clears, and the FSM goes to IDLE.
  - Flush with Count == 0 and no Wren in flight: the latch clears and Done pulses once; no Rden is issued.
- Flush pulse arriving in BURST: latched. The burst completes, then FLUSH is entered from IDLE on the next edge.
- Flush takes priority over a burst threshold when both are true in IDLE.
- Writes continue to be accepted during BURST/FLUSH subject to Space.
- Busy = (state != IDLE).

Test Plan:
- Reset: hold Rst_n=0 for 3 cycles mid-traffic -> all outputs 0 asynchronously; after release, Count=0 and FSM=IDLE.
- Single requester: Req0=1 with Data0=20,10,30,40,50 on successive cycles -> Wren high 5 cycles with Datain 20,10,30,40,50; Gnt0 5 pulses; Count reaches 4 and a burst starts.
  - Rden high 4 cycles; Done pulse; Count ends at 1.
- Contention: Req0 and Req1 both held, Data0=0xA, Data1=0xB -> Datain alternates 0xA,0xB,0xA,...; Gnt0/Gnt1 alternate; no cycle has both grants.
- Full: DEPTH=8, BURST_LEN=8, Req1 held with bursts suppressed until 8 writes -> exactly 8 Gnt1 pulses, then Gnt1=0 while Count=8.
  - Once reads free space, grants resume.
- Flush: Count=3, pulse Flush -> FSM=FLUSH, Rden high 3 cycles, Count=0, Done 1 pulse.
  - Flush with Count=0 -> Done pulse with no Rden.
- Simultaneous: Flush pulsed during the 2nd cycle of a 4-word burst with Count=6 at burst entry -> burst finishes its 4 reads and Done pulses, then FLUSH drains the remaining 2 words and Done pulses again.
  - Mid-burst Rst_n=0 -> Rden drops immediately, no Done.
